bus_xfer_ctrl: RTL

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

---
 rtl/bus_xfer_ctrl_pkg.sv | 28 ++
 rtl/bus_xfer_ctrl_xfer_fifo.sv | 78 +++++++
 rtl/bus_xfer_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types for the bus transfer controller: FSM state encoding and the
// request record {src, dst}.
// Optional build macro used by the top: BUS_XFER_SRC_EQ_DST_CHECK_EN.
package bus_xfer_ctrl_pkg;

   // Controller states; the encoding is fixed so it reads the same in waves.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      LATCH = 2'd2
   } xfer_state_e;

   // Widest select the request record can carry. WIDTH of the top must stay
   // strictly below this so the record always has spare upper bits.
   localparam int unsigned SEL_W_MAX = 16;

   // One transfer request: drive port src onto the bus, load port dst from it.
   typedef struct packed {
      logic [SEL_W_MAX-1:0] src;
      logic [SEL_W_MAX-1:0] dst;
   } xfer_req_t;

   // True while the FSM is in the middle of a transfer.
   function automatic logic state_active(input xfer_state_e s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/bus_xfer_ctrl_xfer_fifo.sv
// Request queue for the bus transfer controller.
// DEPTH entries (power of two, >= 2) of DW bits each. The head entry is
// visible on rd_data whenever the queue is non-empty, so the controller can
// pop and capture the head on the same clock edge. Pointers wrap naturally
// because DEPTH is a power of two.
module xfer_fifo
   import bus_xfer_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] wr_data,
   input  logic          pop,
   output logic [DW-1:0] rd_data,
   output logic          empty,
   output logic          full
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push;
   logic          do_pop;

   // Guard against overflow/underflow even if a caller misbehaves.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign rd_data = mem_q[rd_ptr_q];

   // Next-state pointers and occupancy; push+pop together keeps the count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset empties the queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer controller: queues {src, dst} requests and sequences each one
// as a DRIVE cycle (source enabled onto the bus, bus settles) followed by a
// LATCH cycle (destination strobed, done pulsed).
// Build option BUS_XFER_SRC_EQ_DST_CHECK_EN: when defined, a request whose
// source equals its destination is accepted but dropped, and the err output
// pulses for one cycle instead; when undefined it runs as a normal transfer
// and err does not exist.
module bus_xfer_ctrl
   import bus_xfer_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_src,
   input  logic [WIDTH-1:0] req_dst,
   output logic [WIDTH-1:0] oe_sel,
   output logic             oe_en,
   output logic [WIDTH-1:0] ld_sel,
   output logic             ld_en,
   output logic             busy,
   output logic             done
`ifdef BUS_XFER_SRC_EQ_DST_CHECK_EN
   ,
   output logic             err
`endif
);

   localparam int unsigned EW = 2 * WIDTH;

   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_empty;
   logic             fifo_full;
   logic [EW-1:0]    fifo_wr;
   logic [EW-1:0]    fifo_rd;
   logic             accept;

   xfer_req_t        head_req;
   logic [WIDTH-1:0] head_src;
   logic [WIDTH-1:0] head_dst;
   logic             unused_head_hi;

   xfer_state_e      state_q;
   logic             oe_en_q;
   logic             ld_en_q;
   logic             done_q;
   logic [WIDTH-1:0] oe_sel_q;
   logic [WIDTH-1:0] ld_sel_q;
   logic [WIDTH-1:0] cur_dst_q;

   // Handshake: no pass-through when full, even if the FSM pops this cycle,
   // and nothing is accepted while reset is held.
   assign req_ready = !fifo_full && !reset;
   assign accept    = req_valid && req_ready;
   assign fifo_wr   = {req_src, req_dst};

`ifdef BUS_XFER_SRC_EQ_DST_CHECK_EN
   logic same_sel;
   logic err_q;

   assign same_sel  = (req_src == req_dst);
   assign fifo_push = accept && !same_sel;
   assign err       = err_q;

   // One-cycle error pulse for an accepted request that targets itself.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept && same_sel;
      end
   end
`else
   assign fifo_push = accept;
`endif

   // The head is consumed on entry to DRIVE, either from IDLE or straight
   // out of LATCH for back-to-back transfers.
   assign fifo_pop = !fifo_empty && ((state_q == IDLE) || (state_q == LATCH));

   xfer_fifo #(
      .DEPTH (DEPTH),
      .DW    (EW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (fifo_push),
      .wr_data (fifo_wr),
      .pop     (fifo_pop),
      .rd_data (fifo_rd),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // Unpack the queue head into the shared request record.
   always_comb begin
      head_req     = '0;
      head_req.src = SEL_W_MAX'(fifo_rd[EW-1 -: WIDTH]);
      head_req.dst = SEL_W_MAX'(fifo_rd[WIDTH-1:0]);
   end

   assign head_src = head_req.src[WIDTH-1:0];
   assign head_dst = head_req.dst[WIDTH-1:0];

   // The record is wider than any configured select; its top bits are zero.
   assign unused_head_hi = ^{head_req.src[SEL_W_MAX-1:WIDTH],
                             head_req.dst[SEL_W_MAX-1:WIDTH]};

   // Transfer sequencer. All bus controls are registered so oe_en/ld_en are
   // glitch-free, and ld_en is only ever raised while oe_en is already high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         oe_en_q   <= 1'b0;
         ld_en_q   <= 1'b0;
         done_q    <= 1'b0;
         oe_sel_q  <= '0;
         ld_sel_q  <= '0;
         cur_dst_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               ld_en_q  <= 1'b0;
               done_q   <= 1'b0;
               ld_sel_q <= '0;
               if (!fifo_empty) begin
                  state_q   <= DRIVE;
                  oe_en_q   <= 1'b1;
                  oe_sel_q  <= head_src;
                  cur_dst_q <= head_dst;
               end else begin
                  oe_en_q  <= 1'b0;
                  oe_sel_q <= '0;
               end
            end
            DRIVE: begin
               // Bus has had one cycle to settle; strobe the destination.
               state_q  <= LATCH;
               oe_en_q  <= 1'b1;
               ld_en_q  <= 1'b1;
               ld_sel_q <= cur_dst_q;
               done_q   <= 1'b1;
            end
            LATCH: begin
               ld_en_q  <= 1'b0;
               ld_sel_q <= '0;
               done_q   <= 1'b0;
               if (!fifo_empty) begin
                  state_q   <= DRIVE;
                  oe_en_q   <= 1'b1;
                  oe_sel_q  <= head_src;
                  cur_dst_q <= head_dst;
               end else begin
                  state_q  <= IDLE;
                  oe_en_q  <= 1'b0;
                  oe_sel_q <= '0;
               end
            end
            default: begin
               state_q  <= IDLE;
               oe_en_q  <= 1'b0;
               ld_en_q  <= 1'b0;
               done_q   <= 1'b0;
               oe_sel_q <= '0;
               ld_sel_q <= '0;
            end
         endcase
      end
   end

   assign oe_en  = oe_en_q;
   assign ld_en  = ld_en_q;
   assign done   = done_q;
   assign oe_sel = oe_sel_q;
   assign ld_sel = ld_sel_q;
   assign busy   = state_active(state_q) || !fifo_empty;

endmodule
